// File: rtl/expr_pkg.sv
// Shared definitions for the expression checker: FSM states, character classes, ASCII codes.
package expr_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_NUM  = 3'd1;
    localparam logic [2:0] ST_OPR  = 3'd2;
    localparam logic [2:0] ST_LPR  = 3'd3;
    localparam logic [2:0] ST_RPR  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        CL_DIGIT,
        CL_OP,
        CL_LP,
        CL_RP,
        CL_TERM,
        CL_OTHER
    } cls_e;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;
    localparam logic [7:0] CH_TERM  = 8'h3B;

endpackage

// File: rtl/expr_checker_if.sv
// Character stream in, verdict/status out; master drives characters, slave is the checker.
interface expr_checker_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       in;
    logic             in_valid;
    logic             out;
    logic             err;
    logic [3:0]       depth;
    logic [CNT_W-1:0] ok_cnt;

    modport master (output in, in_valid, input out, err, depth, ok_cnt);
    modport slave  (input in, in_valid, output out, err, depth, ok_cnt);
endinterface

// File: rtl/expr_checker_char_class.sv
// Combinational byte classifier; '-' is an operator only when ALLOW_SUB is set.
module char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_SUB = 0
) (
    input  logic [7:0] ch_i,
    output cls_e       cls_o
);
    always_comb begin
        cls_o = CL_OTHER;
        if (ch_i >= CH_0 && ch_i <= CH_9)
            cls_o = CL_DIGIT;
        else if (ch_i == CH_PLUS || ch_i == CH_STAR || (ALLOW_SUB != 0 && ch_i == CH_MINUS))
            cls_o = CL_OP;
        else if (ch_i == CH_LP)
            cls_o = CL_LP;
        else if (ch_i == CH_RP)
            cls_o = CL_RP;
        else if (ch_i == CH_TERM)
            cls_o = CL_TERM;
    end
endmodule

// File: rtl/expr_checker.sv
// Streaming arithmetic-expression syntax checker; one character per valid cycle, outputs registered (latency 1).
// No backpressure: every character offered with in_valid is consumed on that edge.
module expr_checker
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH  = 4,
    parameter int MAX_DIGITS = 8,
    parameter int ALLOW_SUB  = 0,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           clr_n,
    expr_checker_if.slave  bus
);
    localparam logic [3:0] MAX_DEPTH_C  = 4'(MAX_DEPTH);
    localparam logic [3:0] MAX_DIGITS_C = 4'(MAX_DIGITS);

    cls_e             cls;
    logic [2:0]       st_q, st_d;
    logic [3:0]       depth_q, depth_d;
    logic [3:0]       len_q, len_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic             out_q, out_d;
    logic             err_q, err_d;

    char_class #(.ALLOW_SUB(ALLOW_SUB)) u_class (
        .ch_i  (bus.in),
        .cls_o (cls)
    );

    // Transitions into ST_ERR leave depth/len untouched so they freeze at pre-error values.
    always_comb begin
        st_d     = st_q;
        depth_d  = depth_q;
        len_d    = len_q;
        ok_cnt_d = ok_cnt_q;
        if (bus.in_valid) begin
            if (cls == CL_TERM) begin
                st_d    = ST_IDLE;
                depth_d = 4'd0;
                len_d   = 4'd0;
                if (out_q)
                    ok_cnt_d = ok_cnt_q + CNT_W'(1);
            end else begin
                st_d = ST_ERR;
                case (st_q)
                    ST_IDLE, ST_OPR, ST_LPR: begin
                        if (cls == CL_DIGIT) begin
                            st_d  = ST_NUM;
                            len_d = 4'd1;
                        end else if (cls == CL_LP && depth_q < MAX_DEPTH_C) begin
                            st_d    = ST_LPR;
                            depth_d = depth_q + 4'd1;
                        end
                    end
                    ST_NUM, ST_RPR: begin
                        if (cls == CL_DIGIT && st_q == ST_NUM && len_q < MAX_DIGITS_C) begin
                            st_d  = ST_NUM;
                            len_d = len_q + 4'd1;
                        end else if (cls == CL_OP) begin
                            st_d = ST_OPR;
                        end else if (cls == CL_RP && depth_q != 4'd0) begin
                            st_d    = ST_RPR;
                            depth_d = depth_q - 4'd1;
                        end
                    end
                    default: st_d = ST_ERR;
                endcase
            end
        end
        out_d = (st_d == ST_NUM || st_d == ST_RPR) && depth_d == 4'd0;
        err_d = (st_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            st_q     <= ST_IDLE;
            depth_q  <= 4'd0;
            len_q    <= 4'd0;
            ok_cnt_q <= '0;
            out_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            depth_q  <= depth_d;
            len_q    <= len_d;
            ok_cnt_q <= ok_cnt_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.err    = err_q;
    assign bus.depth  = depth_q;
    assign bus.ok_cnt = ok_cnt_q;
endmodule
